// File: rtl/idat_byte_pack.sv
// Packs the byte-serial zlib stream into 32-bit big-endian words for the IDAT
// CRC32 stage, tracks the payload length and buffers words in a 2-entry FIFO.
module idat_byte_pack #(
  parameter int DATA_WD  = 32,
  parameter int NUM_WD   = 2,
  parameter int LEN_WD   = 32,
  parameter int FIFO_DEP = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               val_i,
  input  logic [7:0]         dat_i,
  input  logic               lst_i,
  output logic               rdy_o,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NUM_WD-1:0]  num_o,
  output logic               lst_o,
  input  logic               rdy_i,
  output logic [LEN_WD-1:0]  len_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_lane;
  logic [DATA_WD-1:0] r_acc;
  logic [LEN_WD-1:0]  r_len;
  logic [DATA_WD-1:0] r_fifo_dat [FIFO_DEP];
  logic [NUM_WD-1:0]  r_fifo_num [FIFO_DEP];
  logic               r_fifo_lst [FIFO_DEP];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_cnt;

  logic               w_rdy;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_clear;
  logic [DATA_WD-1:0] w_word;

  // Lane 0 is the most significant byte, so the first byte lands in [31:24].
  function automatic logic [DATA_WD-1:0] f_lane_insert(
    input logic [DATA_WD-1:0] acc,
    input logic [1:0]         lane,
    input logic [7:0]         byte_in
  );
    logic [DATA_WD-1:0] word;
    word = acc;
    case (lane)
      2'd0:    word[31:24] = byte_in;
      2'd1:    word[23:16] = byte_in;
      2'd2:    word[15:8]  = byte_in;
      2'd3:    word[7:0]   = byte_in;
      default: word        = acc;
    endcase
    return word;
  endfunction

  // Ready depends only on state and FIFO occupancy, never on val_i or rdy_i.
  assign w_rdy    = (r_state == ST_PACK) && (r_cnt < 2'(FIFO_DEP));
  assign w_accept = w_rdy && val_i;
  assign w_word   = f_lane_insert(r_acc, r_lane, dat_i);
  assign w_push   = w_accept && ((r_lane == 2'd3) || lst_i);
  assign w_pop    = (r_cnt != 2'd0) && rdy_i;
  assign w_clear  = (r_state == ST_IDLE) && start_i;

  // Next-state logic; DRAIN leaves on the cycle the last word is popped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_PACK;
        else         w_state_nxt = ST_IDLE;
      end
      ST_PACK: begin
        if (w_accept && lst_i) w_state_nxt = ST_DRAIN;
        else                   w_state_nxt = ST_PACK;
      end
      ST_DRAIN: begin
        if ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)) w_state_nxt = ST_DONE;
        else                                               w_state_nxt = ST_DRAIN;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Byte lane counter and partial-word accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane <= 2'd0;
      r_acc  <= '0;
    end else if (w_clear) begin
      r_lane <= 2'd0;
      r_acc  <= '0;
    end else if (w_accept) begin
      if (w_push) begin
        r_lane <= 2'd0;
        r_acc  <= '0;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_acc  <= w_word;
      end
    end
  end

  // Payload byte counter; wraps silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_len <= '0;
    else if (w_clear)  r_len <= '0;
    else if (w_accept) r_len <= r_len + LEN_WD'(1);
  end

  // Output FIFO; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
      for (int i = 0; i < FIFO_DEP; i++) begin
        r_fifo_dat[i] <= '0;
        r_fifo_num[i] <= '0;
        r_fifo_lst[i] <= 1'b0;
      end
    end else if (w_clear) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
      for (int i = 0; i < FIFO_DEP; i++) begin
        r_fifo_dat[i] <= '0;
        r_fifo_num[i] <= '0;
        r_fifo_lst[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_dat[r_wptr] <= w_word;
        r_fifo_num[r_wptr] <= r_lane;
        r_fifo_lst[r_wptr] <= lst_i;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Head of the FIFO is presented only while it holds a word.
  assign rdy_o  = w_rdy;
  assign val_o  = (r_cnt != 2'd0);
  assign dat_o  = val_o ? r_fifo_dat[r_rptr] : '0;
  assign num_o  = val_o ? r_fifo_num[r_rptr] : '0;
  assign lst_o  = val_o ? r_fifo_lst[r_rptr] : 1'b0;
  assign len_o  = r_len;
  assign done_o = (r_state == ST_DONE);

endmodule

// File: tb/tb_idat_byte_pack.sv
// Self-checking bench for idat_byte_pack: directed scenarios plus random
// payloads under random backpressure, compared against a packing model.
module tb_idat_byte_pack;

  typedef logic [7:0]  bq_t[$];
  typedef logic [34:0] word_t;  // {lst, num[1:0], dat[31:0]}

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic        val_i = 1'b0;
  logic [7:0]  dat_i = 8'h00;
  logic        lst_i = 1'b0;
  logic        rdy_i = 1'b0;
  logic        rdy_o, val_o, lst_o, done_o;
  logic [31:0] dat_o;
  logic [1:0]  num_o;
  logic [31:0] len_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int lst_pop_cyc = -1;
  int done_cyc = -100;
  int done_hits = 0;
  int stall_cyc = 0;
  int to_flag = 0;
  word_t got_q[$];
  word_t exp_q[$];

  idat_byte_pack dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
    .lst_i(lst_i), .rdy_o(rdy_o), .val_o(val_o), .dat_o(dat_o), .num_o(num_o),
    .lst_o(lst_o), .rdy_i(rdy_i), .len_o(len_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every transferred word and every done_o sample.
  always @(negedge clk) begin
    if (val_o === 1'b1 && rdy_i === 1'b1) begin
      got_q.push_back({lst_o, num_o, dat_o});
      if (lst_o === 1'b1) lst_pop_cyc = cyc;
    end
    if (done_o === 1'b1) begin
      done_hits++;
      done_cyc = cyc;
    end
  end

  // Reference: bytes grouped four at a time, first byte most significant.
  function automatic void build_exp(input bq_t b);
    logic [31:0] d;
    int n;
    exp_q.delete();
    for (int w = 0; w * 4 < b.size(); w++) begin
      d = 32'h0;
      n = b.size() - w * 4;
      if (n > 4) n = 4;
      for (int k = 0; k < n; k++) d[31 - 8 * k -: 8] = b[w * 4 + k];
      exp_q.push_back({((w + 1) * 4 >= b.size()) ? 1'b1 : 1'b0, 2'(n - 1), d});
    end
  endfunction

  task automatic do_start;
    got_q.delete();
    done_hits = 0;
    lst_pop_cyc = -1;
    stall_cyc = 0;
    to_flag = 0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic l);
    int t;
    t = 0;
    val_i = 1'b1; dat_i = b; lst_i = l;
    @(negedge clk);
    while (rdy_o !== 1'b1 && t < 500) begin t++; @(negedge clk); end
    stall_cyc += t;
    if (rdy_o !== 1'b1) to_flag = 1;
    @(posedge clk); #1;
    val_i = 1'b0; lst_i = 1'b0;
  endtask

  task automatic run_bytes(input bq_t b, input int gap_max);
    int g;
    for (int i = 0; i < b.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      drive_byte(b[i], (i == b.size() - 1) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic wait_done;
    int t;
    t = 0;
    @(negedge clk);
    while (done_o !== 1'b1 && t < 2000) begin t++; @(negedge clk); end
    if (done_o !== 1'b1) to_flag = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rdy_o, val_o, dat_o, num_o, lst_o, len_o, done_o} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b val=%b dat=%h num=%0d lst=%b len=%0d done=%b, want all 0",
               rdy_o, val_o, dat_o, num_o, lst_o, len_o, done_o);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rdy_o !== 1'b0) begin n_fail++; $display("FAIL idle_rdy: got %b want 0", rdy_o); end
  endtask

  task automatic test_four_bytes;
    bq_t b;
    for (int k = 1; k <= 4; k++) b.push_back(8'(k * 17));
    build_exp(b);
    got_q.delete(); done_hits = 0; stall_cyc = 0; to_flag = 0; lst_pop_cyc = -1;
    rdy_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rdy_o !== 1'b0) begin n_fail++; $display("FAIL four_rdy_pre: got %b want 0", rdy_o); end
    @(posedge clk); #1;
    start_i = 1'b0;
    n_checks++;
    if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL four_rdy_rise: got %b want 1", rdy_o); end
    run_bytes(b, 0);
    wait_done();
    n_checks++;
    if (stall_cyc !== 0) begin n_fail++; $display("FAIL four_stall: got %0d stall cycles want 0", stall_cyc); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL four_cnt: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL four_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (len_o !== 32'd4) begin n_fail++; $display("FAIL four_len: got %0d want 4", len_o); end
    n_checks++;
    if (done_cyc !== lst_pop_cyc + 1 || done_hits !== 1) begin
      n_fail++; $display("FAIL four_done: got cyc %0d hits %0d want cyc %0d hits 1", done_cyc, done_hits, lst_pop_cyc + 1);
    end
    n_checks++;
    if (to_flag !== 0) begin n_fail++; $display("FAIL four_timeout: got %0d want 0", to_flag); end
  endtask

  task automatic test_five_bytes;
    bq_t b;
    for (int k = 1; k <= 5; k++) b.push_back(8'(k * 17));
    build_exp(b);
    rdy_i = 1'b1;
    do_start();
    run_bytes(b, 0);
    wait_done();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL five_cnt: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL five_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (len_o !== 32'd5 || to_flag !== 0) begin n_fail++; $display("FAIL five_len: got %0d (timeout %0d) want 5", len_o, to_flag); end
  endtask

  task automatic test_backpressure;
    bq_t b;
    for (int k = 1; k <= 12; k++) b.push_back(8'(k));
    build_exp(b);
    rdy_i = 1'b0;
    do_start();
    fork
      run_bytes(b, 0);
      begin
        repeat (30) @(negedge clk);
        n_checks++;
        if ({rdy_o, val_o, dat_o, len_o} !== {1'b0, 1'b1, 32'h01020304, 32'd8}) begin
          n_fail++;
          $display("FAIL bp_stall: got rdy=%b val=%b dat=%h len=%0d want rdy=0 val=1 dat=01020304 len=8", rdy_o, val_o, dat_o, len_o);
        end
        @(posedge clk); #1;
        rdy_i = 1'b1;
      end
    join
    wait_done();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_cnt: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (len_o !== 32'd12 || to_flag !== 0) begin n_fail++; $display("FAIL bp_len: got %0d (timeout %0d) want 12", len_o, to_flag); end
  endtask

  task automatic test_simul_push_pop;
    bq_t b;
    for (int k = 1; k <= 8; k++) b.push_back(8'(k));
    build_exp(b);
    rdy_i = 1'b0;
    do_start();
    for (int k = 0; k < 7; k++) drive_byte(b[k], 1'b0);
    rdy_i = 1'b1;
    drive_byte(b[7], 1'b1);
    @(negedge clk);
    n_checks++;
    if ({val_o, dat_o, lst_o} !== {1'b1, 32'h05060708, 1'b1}) begin
      n_fail++; $display("FAIL simul_head: got val=%b dat=%h lst=%b want val=1 dat=05060708 lst=1", val_o, dat_o, lst_o);
    end
    @(posedge clk); #1;
    wait_done();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL simul_cnt: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL simul_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (len_o !== 32'd8 || to_flag !== 0) begin n_fail++; $display("FAIL simul_len: got %0d (timeout %0d) want 8", len_o, to_flag); end
  endtask

  task automatic test_ignored;
    bq_t b;
    b.push_back(8'hAA);
    b.push_back(8'hBB);
    build_exp(b);
    rdy_i = 1'b1;
    do_start();
    drive_byte(8'hAA, 1'b0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lst_i = 1'b1;
    @(posedge clk); #1;
    lst_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rdy_o, len_o} !== {1'b1, 32'd1}) begin
      n_fail++; $display("FAIL ign_state: got rdy=%b len=%0d want rdy=1 len=1", rdy_o, len_o);
    end
    @(posedge clk); #1;
    drive_byte(8'hBB, 1'b1);
    wait_done();
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL ign_word: got %0d words first %h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 35'h0, exp_q[0]);
    end
    n_checks++;
    if (len_o !== 32'd2 || to_flag !== 0) begin n_fail++; $display("FAIL ign_len: got %0d (timeout %0d) want 2", len_o, to_flag); end
  endtask

  task automatic test_reset_mid;
    bq_t b;
    b.push_back(8'h7F);
    build_exp(b);
    rdy_i = 1'b1;
    do_start();
    for (int k = 0; k < 3; k++) drive_byte(8'(8'h10 + k), 1'b0);
    rstn = 1'b0;
    #2;
    n_checks++;
    if ({rdy_o, val_o, dat_o, num_o, lst_o, len_o, done_o} !== 70'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got rdy=%b val=%b dat=%h num=%0d lst=%b len=%0d done=%b, want all 0",
               rdy_o, val_o, dat_o, num_o, lst_o, len_o, done_o);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_start();
    drive_byte(8'h7F, 1'b1);
    wait_done();
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL rstmid_word: got %0d words first %h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 35'h0, exp_q[0]);
    end
    n_checks++;
    if (len_o !== 32'd1 || to_flag !== 0) begin n_fail++; $display("FAIL rstmid_len: got %0d (timeout %0d) want 1", len_o, to_flag); end
  endtask

  task automatic test_random;
    bq_t b;
    int n;
    bit stop;
    for (int p = 0; p < 8; p++) begin
      b.delete();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) b.push_back(8'($urandom));
      build_exp(b);
      do_start();
      stop = 1'b0;
      fork
        begin
          run_bytes(b, 2);
          wait_done();
          stop = 1'b1;
        end
        begin
          while (!stop) begin @(posedge clk); #1; rdy_i = 1'($urandom_range(0, 1)); end
        end
      join
      rdy_i = 1'b1;
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_cnt: got %0d words want %0d", p, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_word%0d: got %h want %h", p, i, got_q[i], exp_q[i]); end
      end
      n_checks++;
      if (len_o !== 32'(n) || to_flag !== 0) begin n_fail++; $display("FAIL rnd%0d_len: got %0d (timeout %0d) want %0d", p, len_o, to_flag, n); end
      n_checks++;
      if (done_cyc !== lst_pop_cyc + 1 || done_hits !== 1) begin
        n_fail++; $display("FAIL rnd%0d_done: got cyc %0d hits %0d want cyc %0d hits 1", p, done_cyc, done_hits, lst_pop_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_four_bytes();
    test_five_bytes();
    test_backpressure();
    test_simul_push_pop();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
